// File: rtl/led_pwm_fader_pkg.sv
// Shared constants for the LED PWM fader.
// Optional fade_busy output is enabled with LED_PWM_FADER_BUSY_EN.
package led_pwm_fader_pkg;

    localparam int DEF_WIDTH      = 18;
    localparam int DEF_LEVEL_BITS = 4;
    localparam int DEF_STEP_DIV   = 250000;

    typedef logic [DEF_LEVEL_BITS-1:0] level_t;

    function automatic int level_max(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: saturating brightness level and PWM compare.
// Adds a per-channel busy flag when LED_PWM_FADER_BUSY_EN is defined.
module led_fade_channel
    import led_pwm_fader_pkg::*;
#(
    parameter int LEVEL_BITS = DEF_LEVEL_BITS
)
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  step,
    input  logic                  target,
    input  logic [LEVEL_BITS-1:0] pwm_cnt,
`ifdef LED_PWM_FADER_BUSY_EN
    output logic                  busy,
`endif
    output logic                  drive
);

    localparam logic [LEVEL_BITS-1:0] LMAX =
        LEVEL_BITS'(level_max(LEVEL_BITS));
    localparam logic [LEVEL_BITS-1:0] ONE = LEVEL_BITS'(1);

    logic [LEVEL_BITS-1:0] r_level;
    logic                  r_drive;
    logic                  w_up;
    logic                  w_dn;

    assign w_up  = target & (r_level != LMAX);
    assign w_dn  = ~target & (r_level != '0);
    assign drive = r_drive;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= '0;
            r_drive <= 1'b0;
        end else begin
            if (step && w_up)
                r_level <= r_level + ONE;
            else if (step && w_dn)
                r_level <= r_level - ONE;
            r_drive <= (r_level > pwm_cnt);
        end
    end

`ifdef LED_PWM_FADER_BUSY_EN
    logic r_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_busy <= 1'b0;
        else
            r_busy <= w_up | w_dn;
    end

    assign busy = r_busy;
`endif

endmodule

// File: rtl/led_pwm_fader.sv
// PWM fader between the red-LED PIO register and the LED pins.
// Define LED_PWM_FADER_BUSY_EN to add the fade_busy output.
module led_pwm_fader
    import led_pwm_fader_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LEVEL_BITS = DEF_LEVEL_BITS,
    parameter int STEP_DIV   = DEF_STEP_DIV
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] led_in,
`ifdef LED_PWM_FADER_BUSY_EN
    output logic             fade_busy,
`endif
    output logic [WIDTH-1:0] led_out
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [LEVEL_BITS-1:0] PWM_LAST =
        LEVEL_BITS'(level_max(LEVEL_BITS) - 1);

    logic [WIDTH-1:0]      r_led_q;
    logic [PW-1:0]         r_presc;
    logic [LEVEL_BITS-1:0] r_pwm_cnt;
    logic                  w_step;

    assign w_step = (r_presc == PRESC_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_led_q   <= '0;
            r_presc   <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_led_q   <= led_in;
            r_presc   <= w_step ? '0 : r_presc + PW'(1);
            r_pwm_cnt <= (r_pwm_cnt == PWM_LAST) ? '0
                       : r_pwm_cnt + LEVEL_BITS'(1);
        end
    end

`ifdef LED_PWM_FADER_BUSY_EN
    logic [WIDTH-1:0] w_busy;
    assign fade_busy = |w_busy;
`endif

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        led_fade_channel #(
            .LEVEL_BITS (LEVEL_BITS)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .step    (w_step),
            .target  (r_led_q[g]),
            .pwm_cnt (r_pwm_cnt),
`ifdef LED_PWM_FADER_BUSY_EN
            .busy    (w_busy[g]),
`endif
            .drive   (led_out[g])
        );
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Randomized bench for led_pwm_fader against a cycle-count reference model.
// Two instances: a fast one (STEP_DIV=2) and a slow one for duty checks.
module tb_led_pwm_fader;

    localparam int W    = 18;
    localparam int LB   = 4;
    localparam int MAXL = 15;
    localparam int SD_F = 2;
    localparam int SD_S = 64;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [W-1:0] led_in = '0;
    logic [W-1:0] led_in_s = '0;
    logic [W-1:0] led_out;
    logic [W-1:0] led_out_s;
`ifdef LED_PWM_FADER_BUSY_EN
    logic         fade_busy;
    logic         fade_busy_s;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    led_pwm_fader #(
        .WIDTH      (W),
        .LEVEL_BITS (LB),
        .STEP_DIV   (SD_F)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .led_in    (led_in),
`ifdef LED_PWM_FADER_BUSY_EN
        .fade_busy (fade_busy),
`endif
        .led_out   (led_out)
    );

    led_pwm_fader #(
        .WIDTH      (W),
        .LEVEL_BITS (LB),
        .STEP_DIV   (SD_S)
    ) u_slow (
        .clk       (clk),
        .reset_n   (reset_n),
        .led_in    (led_in_s),
`ifdef LED_PWM_FADER_BUSY_EN
        .fade_busy (fade_busy_s),
`endif
        .led_out   (led_out_s)
    );

    // Reference model: level per channel, cycles counted since reset release.
    int           m_lvl [2][W];
    logic [W-1:0] m_q   [2];
    logic [W-1:0] m_out [2];
    logic         m_busy[2];
    int           m_cyc [2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < W; i++) m_lvl[k][i] = 0;
            m_q[k] = '0;
            m_out[k] = '0;
            m_busy[k] = 1'b0;
            m_cyc[k] = 0;
        end
    endtask

    task automatic model_edge(input int k, input logic [W-1:0] din);
        int  sd;
        int  pwm;
        bit  stp;
        bit  need;
        bit  b;
        sd  = (k == 0) ? SD_F : SD_S;
        stp = ((m_cyc[k] % sd) == sd - 1);
        pwm = m_cyc[k] % MAXL;
        b   = 1'b0;
        for (int i = 0; i < W; i++) begin
            m_out[k][i] = (m_lvl[k][i] > pwm);
            need = m_q[k][i] ? (m_lvl[k][i] < MAXL) : (m_lvl[k][i] > 0);
            b |= need;
            if (stp && need)
                m_lvl[k][i] += m_q[k][i] ? 1 : -1;
        end
        m_busy[k] = b;
        m_q[k] = din;
        m_cyc[k]++;
    endtask

    task automatic tick();
        model_edge(0, led_in);
        model_edge(1, led_in_s);
        @(posedge clk);
        #1;
        check("out", 32'(led_out), 32'(m_out[0]));
        check("out_s", 32'(led_out_s), 32'(m_out[1]));
`ifdef LED_PWM_FADER_BUSY_EN
        check("busy", 32'(fade_busy), 32'(m_busy[0]));
        check("busy_s", 32'(fade_busy_s), 32'(m_busy[1]));
`endif
    endtask

    // Assert reset mid-cycle, away from any edge; outputs must clear at once.
    task automatic do_reset();
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_out", 32'(led_out), 32'h0);
        check("rst_out_s", 32'(led_out_s), 32'h0);
`ifdef LED_PWM_FADER_BUSY_EN
        check("rst_busy", 32'(fade_busy), 32'h0);
`endif
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int guard;
        int highs;

        // Scenario 1: dark after reset, pwm wraps many times
        do_reset();
        led_in = '0;
        repeat (100) tick();
        check("s1_dark", 32'(led_out), 32'h0);

        // Scenario 2: bit 0 fades fully on
        led_in = 18'h00001;
        repeat (40) tick();
        for (int n = 0; n < 15; n++) begin
            tick();
            check("s2_on", 32'(led_out), 32'h1);
        end

        // Scenario 3: slow instance held at level 5 -> 5/15 duty
        do_reset();
        led_in = '0;
        led_in_s = 18'h00001;
        guard = 0;
        while (m_lvl[1][0] != 5 && guard < 2000) begin
            tick();
            guard++;
        end
        check("s3_reach5", 32'(m_lvl[1][0]), 32'd5);
        led_in_s = '0;
        tick();
        highs = 0;
        for (int n = 0; n < 45; n++) begin
            tick();
            highs += int'(led_out_s[0]);
        end
        check("s3_duty", 32'(highs), 32'd15);

        // Scenario 4: ramp to 8 then fall to 0 without underflow
        do_reset();
        led_in = 18'h00001;
        guard = 0;
        while (m_lvl[0][0] != 8 && guard < 200) begin
            tick();
            guard++;
        end
        check("s4_reach8", 32'(m_lvl[0][0]), 32'd8);
        led_in = '0;
        repeat (40) tick();
        for (int n = 0; n < 30; n++) begin
            tick();
            check("s4_floor", 32'(led_out), 32'h0);
        end

        // Scenario 5: all on, reset at level 10, ramp again from 0
        led_in = 18'h3FFFF;
        guard = 0;
        while (m_lvl[0][0] != 10 && guard < 200) begin
            tick();
            guard++;
        end
        check("s5_reach10", 32'(m_lvl[0][0]), 32'd10);
        do_reset();
        tick();
        check("s5_restart", 32'(led_out), 32'h0);
        repeat (40) tick();
        check("s5_full", 32'(led_out), 32'h3FFFF);

`ifdef LED_PWM_FADER_BUSY_EN
        // Scenario 6: busy tracking with a bit-0 reversal mid-fade
        do_reset();
        led_in = '0;
        repeat (5) tick();
        led_in = 18'h20000;
        tick();
        tick();
        check("s6_busy_rise", 32'(fade_busy), 32'h1);
        repeat (4) tick();
        led_in = 18'h20001;
        repeat (4) tick();
        led_in = 18'h20000;
        tick();
        check("s6_busy_rev", 32'(fade_busy), 32'h1);
        guard = 0;
        while (m_lvl[0][17] != 15 && guard < 200) begin
            tick();
            guard++;
        end
        check("s6_reach15", 32'(m_lvl[0][17]), 32'd15);
        tick();
        check("s6_busy_done", 32'(fade_busy), 32'h0);
`endif

        // Random patterns with occasional asynchronous reset
        do_reset();
        for (int s = 0; s < 250; s++) begin
            led_in = W'($urandom);
            if ($urandom_range(0, 3) == 0)
                led_in_s = W'($urandom);
            if ($urandom_range(0, 40) == 0)
                do_reset();
            repeat ($urandom_range(1, 40)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
